esm_issue_scheduler: RTL



---
 rtl/esm_issue_scheduler_if.sv | 30 +++
 rtl/esm_issue_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/esm_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : esm_issue_scheduler_if
// Brief    : Insert / issue handshake bundle for the ESM issue scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface esm_issue_scheduler_if #(
   parameter int BS = 16
) ();
   localparam int IW = $clog2(BS);

   logic          in_valid;
   logic [IW-1:0] in_index;
   logic          in_ready;
   logic          out_valid;
   logic [IW-1:0] out_index;
   logic          out_ready;
   logic [IW:0]   count;

   modport master (
      output in_valid, in_index, out_ready,
      input  in_ready, out_valid, out_index, count
   );

   modport slave (
      input  in_valid, in_index, out_ready,
      output in_ready, out_valid, out_index, count
   );
endinterface
`default_nettype wire

// File: rtl/esm_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : esm_issue_scheduler
// Brief    : Picks a pending issue index (random rank, or lowest first) and
//            offers it downstream on a valid/ready handshake.
// Config   : ESM_SCHED_RANDOM_EN selects LFSR-driven ranks; undefined = rank 0.
// Revision : 1.0  initial release
// ============================================================================
module esm_issue_scheduler #(
   parameter int          BS   = 16,
   parameter logic [31:0] SEED = 32'hACE1_2468,
   localparam int         IW   = $clog2(BS)
) (
   input wire                   clk,
   input wire                   rst,
   esm_issue_scheduler_if.slave sif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PICK  = 2'd1,
      S_SCAN  = 2'd2,
      S_OFFER = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [BS-1:0] r_cand;
   logic [BS-1:0] w_cand_next;
   logic [BS-1:0] w_set_mask;
   logic [BS-1:0] w_clr_mask;
   logic [IW:0]   r_count;
   logic [IW:0]   w_count_next;
   logic [IW-1:0] r_rank;
   logic [IW-1:0] w_rank_pick;
   logic [IW-1:0] w_scan_idx;
   logic [IW:0]   w_seen;
   logic          w_found;
   logic          r_out_valid;
   logic [IW-1:0] r_out_index;
   logic          w_ins;
   logic          w_hs;
   logic          w_inc;
   logic          w_rank_load;
   logic          w_out_load;

   assign sif.in_ready  = ~rst;
   assign sif.out_valid = r_out_valid;
   assign sif.out_index = r_out_index;
   assign sif.count     = r_count;

   assign w_ins = sif.in_valid & ~rst;
   assign w_hs  = r_out_valid & sif.out_ready;

   // An insert colliding with the retiring index wins, so the count nets to zero.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_ins) w_set_mask[sif.in_index] = 1'b1;
      if (w_hs)  w_clr_mask[r_out_index]  = 1'b1;
      w_cand_next  = (r_cand & ~w_clr_mask) | w_set_mask;
      w_inc        = w_ins & (~r_cand[sif.in_index] |
                              (w_hs & (sif.in_index == r_out_index)));
      w_count_next = r_count + (IW+1)'(w_inc) - (IW+1)'(w_hs);
   end

   // Position of the rank-th set bit, counting from the lowest index.
   always_comb begin
      w_scan_idx = '0;
      w_seen     = '0;
      w_found    = 1'b0;
      for (int i = 0; i < BS; i++) begin
         if (r_cand[i]) begin
            if (!w_found && (w_seen == {1'b0, r_rank})) begin
               w_scan_idx = IW'(i);
               w_found    = 1'b1;
            end
            w_seen = w_seen + (IW+1)'(1);
         end
      end
   end

`ifdef ESM_SCHED_RANDOM_EN
   logic [31:0] r_lfsr;
   logic        w_fb;
   logic [31:0] w_divisor;

   assign w_fb      = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
   assign w_divisor = (r_count == '0) ? 32'd1 : 32'(r_count);
   assign w_rank_pick = IW'(r_lfsr % w_divisor);

   always_ff @(posedge clk) begin
      if (rst) r_lfsr <= SEED;
      else     r_lfsr <= {r_lfsr[30:0], w_fb};
   end
`else
   logic w_unused_seed;

   assign w_rank_pick   = '0;
   assign w_unused_seed = ^SEED;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_rank_load  = 1'b0;
      w_out_load   = 1'b0;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_state_next = S_PICK;
         S_PICK: begin
            w_rank_load  = 1'b1;
            w_state_next = S_SCAN;
         end
         S_SCAN: begin
            w_out_load   = 1'b1;
            w_state_next = S_OFFER;
         end
         S_OFFER: if (w_hs) w_state_next = (w_count_next != '0) ? S_PICK : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand      <= '0;
         r_count     <= '0;
         r_rank      <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
      end else begin
         r_cand  <= w_cand_next;
         r_count <= w_count_next;
         if (w_rank_load) r_rank <= w_rank_pick;
         if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_index <= w_scan_idx;
         end else if (w_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
